// File: rtl/banco_nos_ativos.sv
// Active-node bank: per-slot node registers with conditional update and a
// sequential minimum-score search over all active slots.
module banco_nos_ativos #(
  parameter int unsigned NUM_NA          = 8,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DISTANCIA_WIDTH = 5,
  parameter int unsigned CUSTO_WIDTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ga_atualizar_in,
  input  logic                         ga_desativar_in,
  input  logic [NUM_NA-1:0]            ga_habilitar_in,
  input  logic [ADDR_WIDTH-1:0]        ga_endereco_in,
  input  logic [ADDR_WIDTH-1:0]        ga_anterior_in,
  input  logic [CUSTO_WIDTH-1:0]       ga_menor_vizinho_in,
  input  logic [DISTANCIA_WIDTH-1:0]   ga_distancia_in,
  output logic [ADDR_WIDTH*NUM_NA-1:0] na_endereco_out,
  output logic [NUM_NA-1:0]            na_ativo_out,
  input  logic                         consultar_in,
  output logic                         bna_ocupado_o,
  output logic                         bna_pronto_o,
  output logic                         bna_valido_o,
  output logic [ADDR_WIDTH-1:0]        bna_menor_endereco_o,
  output logic [ADDR_WIDTH-1:0]        bna_menor_anterior_o,
  output logic [DISTANCIA_WIDTH-1:0]   bna_menor_distancia_o,
  output logic                         bna_erro_o
);

  localparam int unsigned CNT_W   = $clog2(NUM_NA) + 1;
  localparam int unsigned IDX_W   = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
  localparam int unsigned SCORE_W = DISTANCIA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, BUSCA, PRONTO} estado_t;

  estado_t state_q, state_d;

  logic [NUM_NA-1:0]          ativo_q;
  logic [ADDR_WIDTH-1:0]      endereco_q  [NUM_NA];
  logic [ADDR_WIDTH-1:0]      anterior_q  [NUM_NA];
  logic [DISTANCIA_WIDTH-1:0] distancia_q [NUM_NA];
  logic [CUSTO_WIDTH-1:0]     vizinho_q   [NUM_NA];

  logic [CNT_W-1:0]           cnt_q;
  logic                       best_found_q;
  logic [SCORE_W-1:0]         best_score_q;
  logic [ADDR_WIDTH-1:0]      best_end_q;
  logic [ADDR_WIDTH-1:0]      best_ant_q;
  logic [DISTANCIA_WIDTH-1:0] best_dist_q;

  logic               inicio;
  logic               scan_en;
  logic               fim;
  logic               melhor;
  logic [IDX_W-1:0]   scan_idx;
  logic [SCORE_W-1:0] cur_score;
  logic               multi_hot;

  // Next state plus evaluation of the slot under the scan pointer
  always_comb begin
    state_d   = state_q;
    inicio    = 1'b0;
    scan_en   = 1'b0;
    fim       = 1'b0;
    scan_idx  = IDX_W'(cnt_q);
    cur_score = SCORE_W'(distancia_q[scan_idx]) + SCORE_W'(vizinho_q[scan_idx]);
    case (state_q)
      IDLE: begin
        if (consultar_in) begin
          state_d = BUSCA;
          inicio  = 1'b1;
        end
      end
      BUSCA: begin
        if (cnt_q == CNT_W'(NUM_NA)) begin
          state_d = PRONTO;
          fim     = 1'b1;
        end else begin
          scan_en = 1'b1;
        end
      end
      PRONTO:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    melhor    = scan_en && ativo_q[scan_idx] &&
                (!best_found_q || (cur_score < best_score_q));
    multi_hot = (ga_habilitar_in & (ga_habilitar_in - NUM_NA'(1))) != '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Slot storage, scan accumulator and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ativo_q               <= '0;
      cnt_q                 <= '0;
      best_found_q          <= 1'b0;
      best_score_q          <= '0;
      best_end_q            <= '0;
      best_ant_q            <= '0;
      best_dist_q           <= '0;
      bna_ocupado_o         <= 1'b0;
      bna_pronto_o          <= 1'b0;
      bna_valido_o          <= 1'b0;
      bna_menor_endereco_o  <= '0;
      bna_menor_anterior_o  <= '0;
      bna_menor_distancia_o <= '0;
      bna_erro_o            <= 1'b0;
      for (int i = 0; i < NUM_NA; i++) begin
        endereco_q[i]  <= '0;
        anterior_q[i]  <= '0;
        distancia_q[i] <= '0;
        vizinho_q[i]   <= '0;
      end
    end else begin
      // Deactivation dominates; same-node updates only accept a shorter path
      for (int i = 0; i < NUM_NA; i++) begin
        if (ga_habilitar_in[i]) begin
          if (ga_desativar_in) begin
            ativo_q[i] <= 1'b0;
          end else if (ga_atualizar_in &&
                       (!ativo_q[i] || (endereco_q[i] != ga_endereco_in) ||
                        (ga_distancia_in < distancia_q[i]))) begin
            ativo_q[i]     <= 1'b1;
            endereco_q[i]  <= ga_endereco_in;
            anterior_q[i]  <= ga_anterior_in;
            distancia_q[i] <= ga_distancia_in;
            vizinho_q[i]   <= ga_menor_vizinho_in;
          end
        end
      end
      bna_erro_o <= (ga_atualizar_in || ga_desativar_in) && multi_hot;

      if (inicio) begin
        cnt_q        <= '0;
        best_found_q <= 1'b0;
        best_score_q <= '0;
        best_end_q   <= '0;
        best_ant_q   <= '0;
        best_dist_q  <= '0;
      end else if (scan_en) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (melhor) begin
          best_found_q <= 1'b1;
          best_score_q <= cur_score;
          best_end_q   <= endereco_q[scan_idx];
          best_ant_q   <= anterior_q[scan_idx];
          best_dist_q  <= distancia_q[scan_idx];
        end
      end

      bna_ocupado_o <= (state_d != IDLE);
      bna_pronto_o  <= fim;
      if (fim) begin
        bna_valido_o          <= best_found_q;
        bna_menor_endereco_o  <= best_end_q;
        bna_menor_anterior_o  <= best_ant_q;
        bna_menor_distancia_o <= best_dist_q;
      end
    end
  end

  assign na_ativo_out = ativo_q;
  for (genvar g = 0; g < NUM_NA; g++) begin : g_na_end
    assign na_endereco_out[ADDR_WIDTH*g +: ADDR_WIDTH] = endereco_q[g];
  end

endmodule

// File: tb/tb_banco_nos_ativos.sv
// Directed self-checking bench for banco_nos_ativos (default parameters).
module tb_banco_nos_ativos;

  logic        clk = 1'b0;
  logic        rst;
  logic        ga_atualizar_in;
  logic        ga_desativar_in;
  logic [7:0]  ga_habilitar_in;
  logic [4:0]  ga_endereco_in;
  logic [4:0]  ga_anterior_in;
  logic [3:0]  ga_menor_vizinho_in;
  logic [4:0]  ga_distancia_in;
  logic [39:0] na_endereco_out;
  logic [7:0]  na_ativo_out;
  logic        consultar_in;
  logic        bna_ocupado_o;
  logic        bna_pronto_o;
  logic        bna_valido_o;
  logic [4:0]  bna_menor_endereco_o;
  logic [4:0]  bna_menor_anterior_o;
  logic [4:0]  bna_menor_distancia_o;
  logic        bna_erro_o;

  int total = 0;
  int bad   = 0;

  banco_nos_ativos dut (
    .clk                   (clk),
    .rst                   (rst),
    .ga_atualizar_in       (ga_atualizar_in),
    .ga_desativar_in       (ga_desativar_in),
    .ga_habilitar_in       (ga_habilitar_in),
    .ga_endereco_in        (ga_endereco_in),
    .ga_anterior_in        (ga_anterior_in),
    .ga_menor_vizinho_in   (ga_menor_vizinho_in),
    .ga_distancia_in       (ga_distancia_in),
    .na_endereco_out       (na_endereco_out),
    .na_ativo_out          (na_ativo_out),
    .consultar_in          (consultar_in),
    .bna_ocupado_o         (bna_ocupado_o),
    .bna_pronto_o          (bna_pronto_o),
    .bna_valido_o          (bna_valido_o),
    .bna_menor_endereco_o  (bna_menor_endereco_o),
    .bna_menor_anterior_o  (bna_menor_anterior_o),
    .bna_menor_distancia_o (bna_menor_distancia_o),
    .bna_erro_o            (bna_erro_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] hab, input logic [4:0] e, input logic [4:0] a,
                    input logic [4:0] d, input logic [3:0] v);
    ga_habilitar_in     = hab;
    ga_endereco_in      = e;
    ga_anterior_in      = a;
    ga_distancia_in     = d;
    ga_menor_vizinho_in = v;
    ga_atualizar_in     = 1'b1;
    step();
    ga_atualizar_in     = 1'b0;
    ga_habilitar_in     = 8'h00;
  endtask

  task automatic de(input logic [7:0] hab);
    ga_habilitar_in = hab;
    ga_desativar_in = 1'b1;
    step();
    ga_desativar_in = 1'b0;
    ga_habilitar_in = 8'h00;
  endtask

  // Runs one search and checks latency, result fields and the single pulse
  task automatic srch(input string tag, input logic v, input logic [4:0] e,
                      input logic [4:0] a, input logic [4:0] d);
    int lat;
    consultar_in = 1'b1;
    step();
    consultar_in = 1'b0;
    lat = 0;
    while (!bna_pronto_o && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"},  32'(lat), 32'd9);
    chk({tag, "_val"},  32'(bna_valido_o), 32'(v));
    chk({tag, "_end"},  32'(bna_menor_endereco_o), 32'(e));
    chk({tag, "_ant"},  32'(bna_menor_anterior_o), 32'(a));
    chk({tag, "_dist"}, 32'(bna_menor_distancia_o), 32'(d));
    step();
    chk({tag, "_pulse"}, 32'({bna_pronto_o, bna_ocupado_o}), 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    ga_atualizar_in = 1'b0;
    ga_desativar_in = 1'b0;
    ga_habilitar_in = 8'h00;
    ga_endereco_in = '0;
    ga_anterior_in = '0;
    ga_menor_vizinho_in = '0;
    ga_distancia_in = '0;
    consultar_in = 1'b0;
    step();
    step();
    chk("rst_ativo", 32'(na_ativo_out), 32'h0);
    chk("rst_end", na_endereco_out[31:0], 32'h0);
    chk("rst_flags", 32'({bna_ocupado_o, bna_pronto_o, bna_valido_o, bna_erro_o}), 32'h0);
    chk("rst_res", 32'({bna_menor_endereco_o, bna_menor_anterior_o, bna_menor_distancia_o}), 32'h0);
    rst = 1'b0;
    step();

    srch("empty", 1'b0, 5'd0, 5'd0, 5'd0);

    wr(8'h04, 5'd5, 5'd1, 5'd3, 4'd2);
    wr(8'h40, 5'd9, 5'd5, 5'd2, 4'd1);
    chk("wr_ativo", 32'(na_ativo_out), 32'h44);
    chk("wr_end2", 32'(na_endereco_out[10 +: 5]), 32'd5);
    chk("wr_end6", 32'(na_endereco_out[30 +: 5]), 32'd9);
    srch("min1", 1'b1, 5'd9, 5'd5, 5'd2);

    // Not-shorter updates to the same node must be rejected
    wr(8'h04, 5'd5, 5'd7, 5'd4, 4'd2);
    wr(8'h04, 5'd5, 5'd7, 5'd3, 4'd0);
    chk("rej_ativo", 32'(na_ativo_out), 32'h44);
    srch("rej", 1'b1, 5'd9, 5'd5, 5'd2);
    wr(8'h04, 5'd5, 5'd3, 5'd1, 4'd2);
    chk("acc_ativo", 32'(na_ativo_out), 32'h44);
    srch("acc_tie", 1'b1, 5'd5, 5'd3, 5'd1);

    de(8'hFF);
    chk("clr_ativo", 32'(na_ativo_out), 32'h00);
    chk("clr_erro", 32'(bna_erro_o), 32'd1);
    wr(8'h02, 5'd11, 5'd2, 5'd2, 4'd1);
    chk("erro_drop", 32'(bna_erro_o), 32'd0);
    wr(8'h10, 5'd20, 5'd6, 5'd1, 4'd2);
    srch("tie", 1'b1, 5'd11, 5'd2, 5'd2);
    de(8'h02);
    chk("de1_ativo", 32'(na_ativo_out), 32'h10);
    chk("de1_end", 32'(na_endereco_out[5 +: 5]), 32'd11);
    srch("after_de", 1'b1, 5'd20, 5'd6, 5'd1);

    wr(8'h10, 5'd7, 5'd1, 5'd9, 4'd0);
    chk("ovw_end4", 32'(na_endereco_out[20 +: 5]), 32'd7);
    srch("ovw", 1'b1, 5'd7, 5'd1, 5'd9);

    wr(8'h11, 5'd3, 5'd4, 5'd5, 4'd5);
    chk("mh_erro", 32'(bna_erro_o), 32'd1);
    chk("mh_ativo", 32'(na_ativo_out), 32'h11);
    chk("mh_end0", 32'(na_endereco_out[0 +: 5]), 32'd3);
    chk("mh_end4", 32'(na_endereco_out[20 +: 5]), 32'd3);
    step();
    chk("mh_erro_drop", 32'(bna_erro_o), 32'd0);

    ga_habilitar_in = 8'h01;
    ga_endereco_in  = 5'd30;
    ga_distancia_in = 5'd0;
    ga_atualizar_in = 1'b1;
    ga_desativar_in = 1'b1;
    step();
    ga_atualizar_in = 1'b0;
    ga_desativar_in = 1'b0;
    ga_habilitar_in = 8'h00;
    chk("both_ativo", 32'(na_ativo_out), 32'h10);
    chk("both_end0", 32'(na_endereco_out[0 +: 5]), 32'd3);

    // Score 31+15 must not wrap below 20
    wr(8'h02, 5'd12, 5'd2, 5'd31, 4'd15);
    wr(8'h10, 5'd8, 5'd6, 5'd20, 4'd0);
    srch("wide", 1'b1, 5'd8, 5'd6, 5'd20);

    consultar_in = 1'b1;
    step();
    consultar_in = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort_ocup", 32'(bna_ocupado_o), 32'd0);
    chk("abort_ativo", 32'(na_ativo_out), 32'h00);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (bna_pronto_o) seen++;
      step();
    end
    chk("abort_nopronto", 32'(seen), 32'd0);

    consultar_in = 1'b1;
    step();
    consultar_in = 1'b0;
    step();
    step();
    step();
    consultar_in = 1'b1;
    step();
    consultar_in = 1'b0;
    chk("busy_ocup", 32'(bna_ocupado_o), 32'd1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bna_pronto_o) seen++;
    end
    chk("busy_pulses", 32'(seen), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
